// File: rtl/mv_select.sv
// mv_select: consumer end of the block-matching compare stream.
// Tracks the minimum-SAD candidate over a window of ROWS candidate words
// and presents the winning motion vector on a valid/ready handshake.
// Optional build macro MV_SELECT_SIGNED_MV_EN: emit the motion vector as a
// two's-complement offset from the window centre instead of raw indices.
module mv_select #(
    parameter int SAD_W = 12,
    parameter int IDX_W = 4,
    parameter int ROWS  = 16,
    parameter int CNT_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [SAD_W+2*IDX_W-1:0]   in_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAD_W-1:0]           out_sad,
    output logic [IDX_W-1:0]           out_mv_x,
    output logic [IDX_W-1:0]           out_mv_y,
    output logic                       busy,
    output logic                       drop_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [SAD_W-1:0]  best_sad;
    logic [IDX_W-1:0]  best_x;
    logic [IDX_W-1:0]  best_y;

    logic [SAD_W-1:0]  cand_sad;
    logic [IDX_W-1:0]  cand_x;
    logic [IDX_W-1:0]  cand_y;
    logic              take;
    logic              last;
    logic [SAD_W-1:0]  nxt_sad;
    logic [IDX_W-1:0]  nxt_x;
    logic [IDX_W-1:0]  nxt_y;

`ifdef MV_SELECT_SIGNED_MV_EN
    // Offset from the window centre: index - 2^(IDX_W-1) is an MSB flip.
    function automatic logic [IDX_W-1:0] mv_map(input logic [IDX_W-1:0] idx);
        mv_map = {~idx[IDX_W-1], idx[IDX_W-2:0]};
    endfunction
`else
    // Raw unsigned index passes straight through.
    function automatic logic [IDX_W-1:0] mv_map(input logic [IDX_W-1:0] idx);
        mv_map = idx;
    endfunction
`endif

    assign cand_sad = in_word[SAD_W+2*IDX_W-1:2*IDX_W];
    assign cand_x   = in_word[2*IDX_W-1:IDX_W];
    assign cand_y   = in_word[IDX_W-1:0];
    assign busy     = (state != S_IDLE);

    // Candidate selection: first word of a window always loads; later words
    // win only on a strictly smaller SAD, so ties keep the earlier row.
    always_comb begin
        take    = 1'b0;
        last    = 1'b0;
        nxt_sad = best_sad;
        nxt_x   = best_x;
        nxt_y   = best_y;
        take    = (cnt == '0) || (cand_sad < best_sad);
        last    = (cnt == LAST_ROW);
        if (take) begin
            nxt_sad = cand_sad;
            nxt_x   = cand_x;
            nxt_y   = cand_y;
        end
    end

    // Window FSM, running minimum, result register and drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            best_sad  <= '1;
            best_x    <= '0;
            best_y    <= '0;
            out_valid <= 1'b0;
            out_sad   <= '1;
            out_mv_x  <= '0;
            out_mv_y  <= '0;
            drop_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACCUM;
                        cnt      <= '0;
                        drop_err <= in_valid;
                    end else if (in_valid) begin
                        drop_err <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        best_sad <= nxt_sad;
                        best_x   <= nxt_x;
                        best_y   <= nxt_y;
                        if (last) begin
                            state     <= S_HOLD;
                            cnt       <= '0;
                            out_valid <= 1'b1;
                            out_sad   <= nxt_sad;
                            out_mv_x  <= mv_map(nxt_x);
                            out_mv_y  <= mv_map(nxt_y);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (in_valid) begin
                        drop_err <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mv_select.sv
// Directed bench for mv_select: minimum tracking, tie handling, first-word
// load, HOLD back-pressure, drop flag, mid-window async reset, gaps and
// ignored start pulses.
module tb_mv_select;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [19:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sad;
    logic [3:0]  out_mv_x;
    logic [3:0]  out_mv_y;
    logic        busy;
    logic        drop_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mv_select dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad),
        .out_mv_x  (out_mv_x),
        .out_mv_y  (out_mv_y),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected motion-vector encoding for a given raw index.
    function automatic logic [31:0] exp_mv(input int idx);
`ifdef MV_SELECT_SIGNED_MV_EN
        exp_mv = 32'((idx - 8) & 15);
`else
        exp_mv = 32'(idx);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_word(input int sad, input int x, input int y);
        in_valid = 1'b1;
        in_word  = {12'(sad), 4'(x), 4'(y)};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sad",   32'(out_sad),   32'hFFF);
        check("rst_mv_x",      32'(out_mv_x),  0);
        check("rst_mv_y",      32'(out_mv_y),  0);
        check("rst_busy",      32'(busy),      0);
        check("rst_drop_err",  32'(drop_err),  0);

        // Window 1: descending SAD 300..285, x=y=row
        pulse_start();
        check("w1_busy", 32'(busy), 1);
        check("w1_drop", 32'(drop_err), 0);
        for (int i = 0; i < 15; i++) send_word(300 - i, i, i);
        check("w1_not_yet", 32'(out_valid), 0);
        send_word(285, 15, 15);
        check("w1_valid", 32'(out_valid), 1);
        check("w1_sad",   32'(out_sad),   285);
        check("w1_x",     32'(out_mv_x),  exp_mv(15));
        check("w1_y",     32'(out_mv_y),  exp_mv(15));
        handshake();
        check("w1_valid_clr", 32'(out_valid), 0);
        check("w1_busy_clr",  32'(busy),      0);
        check("w1_sad_keep",  32'(out_sad),   285);

        // Window 2: tie at rows 3 and 9 keeps row 3
        pulse_start();
        for (int i = 0; i < 16; i++) send_word((i == 3 || i == 9) ? 50 : 400, i, i);
        check("w2_valid", 32'(out_valid), 1);
        check("w2_sad",   32'(out_sad),   50);
        check("w2_x",     32'(out_mv_x),  exp_mv(3));
        check("w2_y",     32'(out_mv_y),  exp_mv(3));
        handshake();

        // Window 3: all SAD=FFF, first word wins
        pulse_start();
        send_word(12'hFFF, 5, 0);
        for (int i = 1; i < 16; i++) send_word(12'hFFF, 1, 1);
        check("w3_valid", 32'(out_valid), 1);
        check("w3_sad",   32'(out_sad),   32'hFFF);
        check("w3_x",     32'(out_mv_x),  exp_mv(5));
        check("w3_y",     32'(out_mv_y),  exp_mv(0));

        // HOLD back-pressure with stray in_valid and start
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin in_valid = 1'b1; in_word = 20'h00123; end
            if (c == 4) start = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; start = 1'b0;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sad",   32'(out_sad),   32'hFFF);
            check("hold_x",     32'(out_mv_x),  exp_mv(5));
            check("hold_busy",  32'(busy),      1);
        end
        check("hold_drop", 32'(drop_err), 1);
        handshake();
        check("hold_rel_valid", 32'(out_valid), 0);
        check("hold_rel_busy",  32'(busy),      0);
        check("hold_rel_drop",  32'(drop_err),  1);

        // Start clears drop flag; abort after 7 words with async reset
        pulse_start();
        check("w4_drop_clr", 32'(drop_err), 0);
        for (int i = 0; i < 7; i++) send_word(10, 9, 9);
        #3 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_busy",  32'(busy),      0);
        check("abort_sad",   32'(out_sad),   32'hFFF);
        check("abort_mv_x",  32'(out_mv_x),  0);
        #10 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort_idle_valid", 32'(out_valid), 0);
        end

        // Window 5: minimum at row 6 (x=2,y=12), gap + ignored start mid-window
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            if (i == 8) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_word((i == 6) ? 100 : 500 + i, (i == 6) ? 2 : i, (i == 6) ? 12 : 15 - i);
        end
        check("w5_not_yet", 32'(out_valid), 0);
        send_word(515, 15, 0);
        check("w5_valid", 32'(out_valid), 1);
        check("w5_sad",   32'(out_sad),   100);
        check("w5_x",     32'(out_mv_x),  exp_mv(2));
        check("w5_y",     32'(out_mv_y),  exp_mv(12));
        check("w5_drop",  32'(drop_err),  0);
        handshake();

        // Stray word in IDLE sets the drop flag
        send_word(7, 1, 1);
        check("idle_drop", 32'(drop_err), 1);
        check("idle_busy", 32'(busy),     0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mv_select.md
Name: mv_select

Overview:
- Consumer end of the compare-stage result stream in the full-search block-matching datapath.
- Accepts one 20-bit candidate word per search row, packed as {SAD 12b, x 4b, y 4b}, and tracks the global minimum-SAD candidate over a full search window of ROWS rows.
- Presents the final motion vector to the downstream stage on a valid/ready handshake and holds it until accepted.

Parameters:
- SAD_W, 12, SAD field width; equals in_word[19:8].
- IDX_W, 4, width of each of the x and y index fields.
- ROWS, 16, number of candidate words per search window.
- CNT_W, 5, row-counter width; must satisfy 2^CNT_W > ROWS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that opens a new search window; accepted only in IDLE.
- in_valid  in  1  in_word carries a valid candidate this cycle.
- in_word  in  20  {sad[19:8], x[7:4], y[3:0]}.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_sad  out  SAD_W  minimum SAD of the window.
- out_mv_x  out  IDX_W  x index of the minimum.
- out_mv_y  out  IDX_W  y index of the minimum.
- busy  out  1  high whenever the state is not IDLE.
- drop_err  out  1  sticky flag: a candidate arrived outside ACCUM.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, cnt=0.
  - best_sad=all-ones, best_x=0, best_y=0.
  - out_valid=0, out_sad=12'hFFF, out_mv_x=0, out_mv_y=0.
  - busy=0, drop_err=0.
  - Asserting reset mid-window discards all partial results; no output is produced for that window.
- All outputs are registered.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM on the next edge; cnt=0; drop_err is loaded with in_valid (it is otherwise cleared).
  - in_valid with start=0 -> word dropped, drop_err set.
- ACCUM, on each in_valid:
  - cnt==0: load the word unconditionally (best_sad, best_x, best_y).
  - cnt>0: replace the best only if in_word[19:8] < best_sad, using an unsigned compare. On a tie the earlier word is kept.
  - cnt increments on every accepted word.
  - in_valid=0 cycles are gaps: no state change, no timeout.
  - start in ACCUM is ignored and does not restart the window.
- Window completion:
  - Trigger: in_valid while cnt==ROWS-1.
  - Next edge: state goes to HOLD; out_valid=1; out_sad/out_mv_x/out_mv_y load the final best, including that last word.
  - Latency from the last word to out_valid is 1 cycle.
- HOLD:
  - out_valid and out_* are held stable until out_ready=1.
  - On the out_ready=1 edge: out_valid=0 next cycle, state goes to IDLE, out_* keep their last value.
  - in_valid in HOLD -> word dropped, drop_err set.
  - start in HOLD is ignored; the upstream stage must wait for busy=0.
- Throughput: the earliest new start is the cycle after the handshake, so the window period is ROWS+2 cycles minimum.
- out_* change only on entry to HOLD (or on reset).

Optional Feature:
- Macro: MV_SELECT_SIGNED_MV_EN.
- Defined: out_mv_x and out_mv_y are emitted as two's-complement offsets from the window centre, value = index - 8, implemented as an MSB inversion. Index 0 -> 4'b1000 (-8), index 8 -> 4'b0000, index 15 -> 4'b0111 (+7).
- Port widths and reset values are unchanged.
- Undefined: raw unsigned indices are passed through.

Test Plan:
- Reset, then start, then 16 words with SAD descending from 300 to 285, x=y=row -> one cycle after row 15, out_valid=1, out_sad=285, x=15, y=15.
- Window where rows 3 and 9 both carry SAD=50 and all other rows SAD=400 -> out_sad=50, out_mv_y=3 (tie keeps the earlier row).
- All 16 words SAD=12'hFFF with x=5, y=0 on the first word -> out_sad=FFF, x=5, y=0 (first-word load).
- Hold out_ready=0 for 10 cycles after out_valid; pulse in_valid and start during HOLD -> outputs stable, drop_err=1, busy=1. Then out_ready=1 -> out_valid=0 next cycle, busy=0. The next start clears drop_err.
- Assert rst_n=0 asynchronously after 7 words, release, restart, send 16 words -> result reflects only the new window; out_valid was never asserted for the aborted one.
- With MV_SELECT_SIGNED_MV_EN defined, minimum at x=2, y=12 -> out_mv_x=4'b1010 (-6), out_mv_y=4'b0100 (+4).
